// File: rtl/lsu_mem_port.sv
// Load/store memory port: one outstanding access, misalignment detection,
// store lane formatting and raw read-word return for the alignment stage.
package lsu_pkg;
    typedef enum logic [2:0] {
        LOAD_OP_LB, LOAD_OP_LBU, LOAD_OP_LH, LOAD_OP_LHU, LOAD_OP_LW
    } LoadOp_t;
    typedef enum logic [1:0] {
        STORE_OP_SB, STORE_OP_SH, STORE_OP_SW
    } StoreOp_t;
endpackage

module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  LoadOp_t     req_load_op_i,
    input  StoreOp_t    req_store_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_addr_lo_o,
    output LoadOp_t     rsp_load_op_o,
    output logic        rsp_misaligned_o,
    output logic        stall_o
);
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        accept, mis, trap_now;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_wstrb;

    // Captured access, held for the bus phase.
    logic        we_q, mis_q;
    logic [1:0]  addr_lo_q;
    LoadOp_t     load_op_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_wstrb_q;

    // Response fields, only rewritten when a response is produced.
    logic [31:0] rsp_rdata_q;
    logic [1:0]  rsp_addr_lo_q;
    LoadOp_t     rsp_load_op_q;
    logic        rsp_mis_q;

    assign accept   = req_valid_i & (state_q == S_IDLE);
    assign trap_now = mis & MISALIGN_TRAP;

    // Misalignment: halves need addr[0]=0, words need addr[1:0]=0.
    always_comb begin
        mis = 1'b0;
        if (req_we_i) begin
            case (req_store_op_i)
                STORE_OP_SH: mis = req_addr_i[0];
                STORE_OP_SW: mis = |req_addr_i[1:0];
                default:     mis = 1'b0;
            endcase
        end else begin
            case (req_load_op_i)
                LOAD_OP_LH, LOAD_OP_LHU: mis = req_addr_i[0];
                LOAD_OP_LW:              mis = |req_addr_i[1:0];
                default:                 mis = 1'b0;
            endcase
        end
    end

    // Store data replicated across lanes, strobes select the addressed bytes.
    always_comb begin
        fmt_wdata = req_wdata_i;
        fmt_wstrb = 4'b1111;
        case (req_store_op_i)
            STORE_OP_SB: begin
                fmt_wdata = {4{req_wdata_i[7:0]}};
                fmt_wstrb = 4'b0001 << req_addr_i[1:0];
            end
            STORE_OP_SH: begin
                fmt_wdata = {2{req_wdata_i[15:0]}};
                fmt_wstrb = req_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        if (!req_we_i) fmt_wstrb = 4'b0000;
    end

    // State register.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next state: trapped accesses skip the bus entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid_i) state_d = trap_now ? S_RESP : S_BUS;
            S_BUS:   if (mem_ready_i) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the access on accept and the response on completion.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            we_q          <= 1'b0;
            mis_q         <= 1'b0;
            addr_lo_q     <= 2'b00;
            load_op_q     <= LOAD_OP_LW;
            mem_addr_q    <= 32'h0;
            mem_wdata_q   <= 32'h0;
            mem_wstrb_q   <= 4'b0000;
            rsp_rdata_q   <= 32'h0;
            rsp_addr_lo_q <= 2'b00;
            rsp_load_op_q <= LOAD_OP_LW;
            rsp_mis_q     <= 1'b0;
        end else begin
            if (accept) begin
                we_q        <= req_we_i;
                mis_q       <= mis;
                addr_lo_q   <= req_addr_i[1:0];
                load_op_q   <= req_load_op_i;
                mem_addr_q  <= {req_addr_i[31:2], 2'b00};
                mem_wdata_q <= fmt_wdata;
                mem_wstrb_q <= fmt_wstrb;
            end
            if (accept && trap_now) begin
                rsp_rdata_q   <= 32'h0;
                rsp_addr_lo_q <= req_addr_i[1:0];
                rsp_load_op_q <= req_load_op_i;
                rsp_mis_q     <= 1'b1;
            end else if (state_q == S_BUS && mem_ready_i) begin
                rsp_rdata_q   <= we_q ? 32'h0 : mem_rdata_i;
                rsp_addr_lo_q <= addr_lo_q;
                rsp_load_op_q <= load_op_q;
                rsp_mis_q     <= mis_q;
            end
        end
    end

    assign req_ready_o      = (state_q == S_IDLE);
    assign mem_valid_o      = (state_q == S_BUS);
    assign rsp_valid_o      = (state_q == S_RESP);
    assign stall_o          = (state_q == S_BUS) | ((state_q == S_IDLE) & req_valid_i);
    assign mem_addr_o       = mem_addr_q;
    assign mem_wdata_o      = mem_wdata_q;
    assign mem_wstrb_o      = mem_wstrb_q;
    assign rsp_rdata_o      = rsp_rdata_q;
    assign rsp_addr_lo_o    = rsp_addr_lo_q;
    assign rsp_load_op_o    = rsp_load_op_q;
    assign rsp_misaligned_o = rsp_mis_q;
endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store memory port for the kianv 5-stage pipeline. It sits between the memory stage request (address, op, store data) and the external data-memory bus, and drives the load-alignment stage. It accepts one access at a time and detects misaligned accesses. For stores it generates byte strobes and lane-replicated write data. It holds the bus handshake and returns the raw, unaligned read word plus the address low bits and load op, so the alignment stage can extract and extend the result.

## Interface
Parameters:
- MISALIGN_TRAP, default 1: 1 means misaligned accesses are flagged and never reach the bus; 0 means they go to the bus with the word-aligned address and the flag still set.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- req_valid  in  1  memory-stage access request
- req_ready  out  1  port idle, request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_load_op  in  LoadOp_t  LB/LBU/LH/LHU/LW, used when req_we=0
- req_store_op  in  StoreOp_t  SB/SH/SW, used when req_we=1
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- mem_valid  out  1  bus request
- mem_ready  in  1  bus completion, sampled while mem_valid=1
- mem_addr  out  32  {req_addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte strobes, 4'b0000 for loads
- mem_rdata  in  32  read word, valid when mem_ready=1
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  raw read word (0 for stores and trapped accesses)
- rsp_addr_lo  out  2  captured req_addr[1:0]
- rsp_load_op  out  LoadOp_t  captured load op
- rsp_misaligned  out  1  misaligned access flag
- stall  out  1  pipeline hold request

## Operation
- State machine has three states: IDLE, BUS, RESP. req_ready = (state==IDLE).
- IDLE: on accept, capture we, ops, addr, and formatted store data/strobes. Compute mis:
  - half-word (LH/LHU/SH) with addr[0]=1
  - word (LW/SW) with addr[1:0]≠0
  - MISALIGN_TRAP=1 and mis=1: go to RESP without a bus access; rsp_rdata=0, rsp_misaligned=1.
  - otherwise go to BUS.
- BUS: mem_valid=1. mem_addr, mem_wdata and mem_wstrb stay stable until mem_ready=1. On mem_ready, capture mem_rdata for loads (0 for stores) and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_* fields hold their values until the next RESP.
- Store formatting:
  - SB: wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0]
  - SH: wdata={2{d[15:0]}}, wstrb=addr[1]?4'b1100:4'b0011
  - SW: wdata=d, wstrb=4'b1111
- stall = (state==BUS) | (state==IDLE & req_valid). It is low in RESP so the pipeline consumes the response that cycle.
- req_valid arriving while not idle is ignored and held off by req_ready=0. Only one access is ever outstanding.

## Timing
- Reset (resetn=0, asynchronous): state=IDLE, mem_valid=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_addr_lo=0, rsp_load_op=LOAD_OP_LW, rsp_misaligned=0. req_ready=1 and stall=req_valid.
- Reset mid-access drops mem_valid immediately and no response is produced. The bus must tolerate an abandoned request.
- Accept in cycle N, mem_valid from N+1. If mem_ready in cycle M≥N+1, rsp_valid in M+1. Minimum latency is 2 cycles from acceptance.
- Trapped misaligned access: accept N, rsp_valid in N+1, mem_valid never asserted.
- Back-to-back: the next request is accepted in the cycle after RESP, at the earliest, so throughput is one access per 3 cycles minimum.
- mem_ready while mem_valid=0 is ignored.

## Test plan
- LW addr 0x100, mem_ready after 3 wait cycles with rdata 0xDEADBEEF -> mem_addr=0x100, wstrb=0, mem_valid high for 4 cycles. Then rsp_valid one cycle with rsp_rdata=0xDEADBEEF, rsp_addr_lo=0, stall low in RESP.
- SB addr 0x203, wdata 0x000000A5 -> mem_addr=0x200, mem_wdata=0xA5A5A5A5, mem_wstrb=4'b1000. rsp_rdata=0, rsp_misaligned=0.
- SH addr 0x42, wdata 0x1234 -> mem_wdata=0x12341234, wstrb=4'b1100. LHU addr 0x42 -> rsp_addr_lo=2'b10, rsp_load_op=LHU.
- MISALIGN_TRAP=1: LW addr 0x101 -> rsp_valid at acceptance+1, rsp_misaligned=1, rsp_rdata=0, mem_valid never high. With MISALIGN_TRAP=0 the same request goes to the bus at 0x100 with the flag set.
- Assert resetn=0 during BUS -> mem_valid falls without a clock edge, no rsp_valid. After release, LW addr 0x0 completes normally.
- req_valid held high across three loads with mem_ready always 1 -> each accepted only in IDLE, responses spaced 3 cycles apart, stall pattern high,high,low per access.
